// File: rtl/tsv_scan_pkg.sv
// rtl/tsv_scan_pkg.sv - shared TSV link parameters and scan FSM state type
// Imported by the scanner and by the coder-side and decoder-side top levels.
package tsv_scan_pkg;

  localparam int N_TSV     = 9;
  localparam int MAX_FAULT = 6;
  localparam int NUM_PAT   = N_TSV + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } scan_state_e;

endpackage

// File: rtl/tsv_popcount.sv
// rtl/tsv_popcount.sv - combinational population count of a TSV flag vector
module tsv_popcount #(
  parameter int N_TSV = 9,
  parameter int CW    = 4
) (
  input  logic [N_TSV-1:0] vec_i,
  output logic [CW-1:0]    cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N_TSV; i++) begin
      cnt_o = cnt_o + {{(CW-1){1'b0}}, vec_i[i]};
    end
  end

endmodule

// File: rtl/tsv_fault_scan.sv
// rtl/tsv_fault_scan.sv - TSV open/short scanner producing the faulty-TSV map
// Drives all-zero, all-one and walking-one patterns and ORs any receive mismatch into f_flag.
module tsv_fault_scan #(
  parameter int N_TSV      = tsv_scan_pkg::N_TSV,
  parameter int MAX_FAULT  = tsv_scan_pkg::MAX_FAULT,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [N_TSV-1:0] tsv_rx,
  output logic [N_TSV-1:0] tsv_tx,
  output logic             test_mode,
  output logic [N_TSV-1:0] f_flag,
  output logic [3:0]       fault_cnt,
  output logic             repairable,
  output logic             busy,
  output logic             done
);

  import tsv_scan_pkg::*;

  localparam int NPAT = N_TSV + 2;
  localparam int PW   = $clog2(NPAT);

  scan_state_e      state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [PW-1:0]    idx_q, idx_d;
  logic [N_TSV-1:0] tx_q, tx_d;
  logic [N_TSV-1:0] acc_q, acc_d;
  logic [N_TSV-1:0] flag_q, flag_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic             rep_q, rep_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [3:0]       acc_cnt;

  // Pattern k: 0 -> all-zero, 1 -> all-one, k>=2 -> one-hot on bit k-2.
  function automatic logic [N_TSV-1:0] pattern(input logic [PW-1:0] idx);
    logic [N_TSV-1:0] p;
    p = '0;
    if (idx == PW'(1)) begin
      p = '1;
    end else if (idx >= PW'(2)) begin
      p = {{(N_TSV-1){1'b0}}, 1'b1} << (idx - PW'(2));
    end
    return p;
  endfunction

  tsv_popcount #(
    .N_TSV (N_TSV),
    .CW    (4)
  ) u_popcount (
    .vec_i (acc_q),
    .cnt_o (acc_cnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    acc_d   = acc_q;
    flag_d  = flag_q;
    fcnt_d  = fcnt_q;
    rep_d   = rep_q;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = '0;
        // busy_q still covers the done cycle, so a start there is dropped.
        if (start && !busy_q) begin
          state_d = SETTLE;
          idx_d   = '0;
          tx_d    = pattern('0);
          cnt_d   = 4'(SETTLE_CYC);
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        acc_d = acc_q | (tx_q ^ tsv_rx);
        if (idx_q == PW'(NPAT-1)) begin
          state_d = DONE;
          tx_d    = '0;
        end else begin
          state_d = SETTLE;
          idx_d   = idx_q + PW'(1);
          tx_d    = pattern(idx_q + PW'(1));
          cnt_d   = 4'(SETTLE_CYC);
        end
      end
      DONE: begin
        flag_d  = acc_q;
        fcnt_d  = acc_cnt;
        rep_d   = (int'(acc_cnt) <= MAX_FAULT);
        done_d  = 1'b1;
        acc_d   = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || (state_q == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= '0;
      acc_q   <= '0;
      flag_q  <= '0;
      fcnt_q  <= '0;
      rep_q   <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      acc_q   <= acc_d;
      flag_q  <= flag_d;
      fcnt_q  <= fcnt_d;
      rep_q   <= rep_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign tsv_tx     = tx_q;
  assign test_mode  = busy_q;
  assign f_flag     = flag_q;
  assign fault_cnt  = fcnt_q;
  assign repairable = rep_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/tsv_fault_scan.md
TSV_FAULT_SCAN -- requirements
Module: tsv_fault_scan

Interface
REQ-001 SHALL have parameter N_TSV, default 9, number of TSV lines in the 3-6 link (x+y).
REQ-002 SHALL have parameter MAX_FAULT, default 6, maximum faulty TSVs the FNS adders/coder can repair.
REQ-003 SHALL have parameter SETTLE_CYC, default 2 (legal 1..15), cycles a test pattern is held before the receive side is sampled.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clock and reset.
REQ-005 SHALL have port: clock  input  1  system clock; all state changes on its rising edge.
REQ-006 SHALL have port: reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port: start  input  1  one-cycle request to begin a scan.
REQ-008 SHALL have port: tsv_rx  input  N_TSV  TSV levels seen at the receiver side.
REQ-009 SHALL have port: tsv_tx  output  N_TSV  test pattern driven onto the TSVs.
REQ-010 SHALL have port: test_mode  output  1  high while scanning, so the coder output is muxed off the TSVs.
REQ-011 SHALL have port: f_flag  output  N_TSV  faulty flags; bit 0 is the first TSV; this output feeds the FNS adders on both sides.
REQ-012 SHALL have port: fault_cnt  output  4  number of set f_flag bits.
REQ-013 SHALL have port: repairable  output  1  high when fault_cnt <= MAX_FAULT.
REQ-014 SHALL have port: busy  output  1  scan in progress.
REQ-015 SHALL have port: done  output  1  one-cycle pulse when a new f_flag is published.

Function
REQ-016 SHALL implement the FSM states IDLE, SETTLE, CHECK and DONE.
REQ-017 SHALL take IDLE -> SETTLE when start=1 in IDLE, load pattern 0 into tsv_tx and load the settle counter with SETTLE_CYC.
REQ-018 SHALL, in SETTLE, decrement the counter each cycle and go to CHECK in the cycle after the counter reads 1.
REQ-019 SHALL, in CHECK, OR (tsv_tx XOR tsv_rx) into an internal accumulator; on the last pattern it goes to DONE, otherwise it loads the next pattern, reloads the counter and returns to SETTLE.
REQ-020 SHALL use NUM_PAT = N_TSV+2 patterns, in this order: all-zero, all-one, then walking-one with bit 0 first through bit N_TSV-1.
REQ-021 SHALL, in DONE, load f_flag from the accumulator, update fault_cnt and repairable, pulse done for 1 cycle, clear the accumulator and go to IDLE.
REQ-022 SHALL assert done exactly NUM_PAT*(SETTLE_CYC+1)+1 cycles after the edge that samples start (34 with the defaults).
REQ-023 SHALL keep busy and test_mode high in SETTLE, CHECK and DONE, and low in IDLE.
REQ-024 SHALL drive tsv_tx to 0 in IDLE.
REQ-025 SHALL ignore start while busy=1, with no restart and no queuing.
REQ-026 SHALL hold f_flag, fault_cnt and repairable stable during a scan and change them only in DONE, so the coder never sees a partial map.
REQ-027 SHALL, when start=1 in the DONE cycle, ignore that start; a new scan needs start in IDLE.
REQ-028 SHALL compute fault_cnt as a saturating-free popcount; width 4 covers N_TSV up to 15.

Reset
REQ-029 SHALL, with reset=1 at a rising edge, set state to IDLE and set f_flag, fault_cnt, the accumulator, the counter, the pattern index, tsv_tx, done and busy to 0, test_mode to 0 and repairable to 1.
REQ-030 SHALL, on reset during a scan, abandon the scan with no done pulse and no partial f_flag update.
REQ-031 SHALL give reset priority over start in the same cycle.

Structure
REQ-032 SHALL take N_TSV, MAX_FAULT, NUM_PAT and the FSM state enum from shared package tsv_scan_pkg; the coder-side and decoder-side top levels import the same package.
REQ-033 SHALL place the popcount in one sub-module, tsv_popcount, which is combinational and parameterised by N_TSV.
REQ-034 SHALL generate patterns from the pattern index, with no pattern ROM.

Verification
REQ-035 SHALL verify: loopback tsv_rx=tsv_tx, pulse start -> done at cycle 34, f_flag=9'b000000000, fault_cnt=0, repairable=1.
REQ-036 SHALL verify: tsv_rx[3] stuck at 0 -> f_flag=9'b000001000, fault_cnt=1, repairable=1.
REQ-037 SHALL verify: tsv_rx[0] stuck at 1 and tsv_rx[8] stuck at 0 -> f_flag=9'b100000001, fault_cnt=2; feeding this f_flag to the adders/coder/decoder with 100 random data values gives dataout==datain.
REQ-038 SHALL verify: TSVs 0..6 stuck at 0 -> f_flag=9'b001111111, fault_cnt=7, repairable=0.
REQ-039 SHALL verify: start pulsed again at cycles 5 and 33 of a scan -> a single done at cycle 34, and busy drops in cycle 35.
REQ-040 SHALL verify: scan with the TSV 3 fault completes, then a second scan is reset at cycle 10 -> no done, f_flag=0, tsv_tx=0, test_mode=0, repairable=1.
